// File: rtl/acc_pkg.sv
// acc_pkg: opcode and FSM state types shared by the accumulator datapath.
// Imported by the ALU and the top-level datapath.
package acc_pkg;

    localparam int OPW = 3;

    typedef enum logic [OPW-1:0] {
        OP_LDA = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_MUL = 3'b110,
        OP_NOP = 3'b111
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_nbits.sv
// alu_nbits: combinational single-cycle ALU for the accumulator datapath.
// LDA passes b through; carry is ADD carry-out or SUB borrow, else 0.
module alu_nbits
    import acc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] y,
    output logic             carry
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] dif;

    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};

    // Select the result of the requested single-cycle operation
    always_comb begin
        y     = a;
        carry = 1'b0;
        case (op)
            OP_LDA: y = b;
            OP_ADD: begin
                y     = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            OP_SUB: begin
                y     = dif[WIDTH-1:0];
                carry = dif[WIDTH];
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            default: begin
                y     = a;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/acc_datapath_seq.sv
// acc_datapath_seq: NACC accumulators behind a valid/ready command port,
// with Z/C flags and a WIDTH-cycle shift-add multiply.
module acc_datapath_seq
    import acc_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NACC  = 4,
    localparam int AW    = (NACC > 1) ? $clog2(NACC) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OPW-1:0]   cmd_op,
    input  logic [AW-1:0]    cmd_dst,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [AW-1:0]    rd_sel,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             flag_z,
    output logic             flag_c,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state;
    state_e           state_nxt;
    logic [WIDTH-1:0] acc [NACC];
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] prod_nxt;
    logic [CW-1:0]    cnt;
    logic [AW-1:0]    dst;
    op_e              op;
    logic             accept;
    logic             dst_ok;
    logic             rd_ok;
    logic             mul_go;
    logic             mul_last;
    logic [WIDTH-1:0] acc_cur;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] alu_y;
    logic             alu_c;

    assign op       = op_e'(cmd_op);
    assign dst_ok   = int'(cmd_dst) < NACC;
    assign rd_ok    = int'(rd_sel) < NACC;
    assign accept   = cmd_valid && cmd_ready;
    assign mul_go   = accept && dst_ok && (op == OP_MUL);
    assign mul_last = (cnt == CW'(WIDTH - 1));
    assign acc_cur  = dst_ok ? acc[cmd_dst] : '0;
    assign opnd     = (op == OP_LDA) ? cmd_a : cmd_b;
    assign prod_nxt = mplier[0] ? prod + mcand : prod;
    assign result   = rd_ok ? acc[rd_sel] : '0;

    alu_nbits #(.WIDTH(WIDTH)) u_alu (
        .a     (acc_cur),
        .b     (opnd),
        .op    (op),
        .y     (alu_y),
        .carry (alu_c)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state: enter MUL on an accepted multiply, leave after the last step
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mul_go) state_nxt = MUL;
            MUL:     if (mul_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: handshake and busy indication
    always_comb begin
        cmd_ready = (state == IDLE) && !reset;
        busy      = (state == MUL);
    end

    // Shift-add multiplier registers: load on accept, step once per MUL cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
            dst    <= '0;
        end else if (mul_go) begin
            mcand  <= acc_cur;
            mplier <= cmd_b;
            prod   <= '0;
            cnt    <= '0;
            dst    <= cmd_dst;
        end else if (state == MUL) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            prod   <= prod_nxt;
            cnt    <= cnt + CW'(1);
        end
    end

    // Accumulators, flags and done: single-cycle ops on accept, MUL on its last step
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NACC; i++) acc[i] <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == MUL && mul_last) begin
                acc[dst] <= prod_nxt;
                flag_z   <= (prod_nxt == '0);
                flag_c   <= 1'b0;
                done     <= 1'b1;
            end else if (accept && !mul_go) begin
                done <= 1'b1;
                if (dst_ok && op != OP_NOP) begin
                    acc[cmd_dst] <= alu_y;
                    flag_z       <= (alu_y == '0);
                    flag_c       <= alu_c;
                end
            end
        end
    end

endmodule
